poly_byte_encode: RTL
=====================

# poly_byte_encode

Streaming polynomial-to-byte encoder (ByteEncode_D). It is the writer counterpart of the byte-to-bit unpacking and sampling path. It accepts 256 coefficients of one polynomial, one per handshake, and packs the low D bits of each LSB-first into a contiguous bit stream. It emits that stream as 32·D bytes over a valid/ready byte interface. It sits at the output of the polynomial datapath, feeding ciphertext/public-key serialization.

## Interface
- D, 12: bits per coefficient; legal 1..12.
- N, 256: coefficients per frame; fixed to the package constant.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- coeff_i  in  12  coefficient; only bits [D-1:0] are packed
- coeff_valid  in  1  coefficient offered
- coeff_ready  out  1  encoder accepts coefficient this cycle
- byte_o  out  8  output byte
- byte_valid  out  1  byte_o valid
- byte_ready  in  1  downstream accepts byte
- byte_last  out  1  qualifies the final byte (index 32·D−1) of the frame
- frame_done  out  1  one-cycle pulse after the last byte handshake
- range_err  out  1  sticky; present only with the macro (see Configuration)

## Operation
- Stream bit D·i+j = bit j of coefficient i. Byte k = stream bits 8k..8k+7, with bit j at byte bit j.
- Accumulator: 20-bit acc, plus 5-bit fill (pending bit count, 0..19).
- Accept: coeff_ready = (fill < 8) && (coeff_cnt < N).
  - On coeff_valid && coeff_ready: acc |= (coeff_i[D-1:0] << fill); fill += D; coeff_cnt++.
- Emit: byte_valid = (fill ≥ 8); byte_o = acc[7:0].
  - On byte_valid && byte_ready: acc >>= 8; fill −= 8; byte_cnt++.
- Accept and emit are mutually exclusive by construction (fill<8 vs fill≥8). There is no simultaneous update.
- States:
  - ACCEPT: coeff_cnt < N.
  - FLUSH: coeff_cnt == N and fill > 0, draining the remaining bytes.
  - Leaving FLUSH on the last byte handshake: coeff_cnt and byte_cnt clear to 0, frame_done pulses next cycle, and the state returns to ACCEPT.
- 256·D is a multiple of 8, so fill is exactly 0 at frame end. No padding.
- byte_last = byte_valid && (byte_cnt == 32·D−1).
- Backpressure: while byte_valid && !byte_ready, byte_o, byte_valid and byte_last hold stable, and coeff_ready stays low.
- Reset mid-frame: the partial frame is discarded. acc, fill and counters return to 0. No frame_done.

## Timing
- Reset values: coeff_ready=1, byte_valid=0, byte_o=0, byte_last=0, frame_done=0, range_err=0.
- All outputs derive from registers only. There is no combinational path from coeff_valid or byte_ready to any output.
- Latency: a coefficient accepted at edge n makes its first byte visible in cycle n+1, when fill reaches ≥8.
- Throughput with byte_ready held high: D bytes per 8 coefficient-accept/byte-emit cycles. A full frame takes 256 + 32·D cycles.
- frame_done asserts in the cycle after the byte_last handshake, for exactly one cycle.

## Configuration
- ENCODE_RANGE_CHECK_EN defined:
  - range_err is a port.
  - It sets on any accepted coeff_i with a nonzero bit above D−1.
  - It clears only on reset.
  - Packing still drops the upper bits.
- ENCODE_RANGE_CHECK_EN undefined: the port and its logic are absent, and upper bits are silently ignored.

## Structure
- Shared package kyber_pkg:
  - KYBER_N=256
  - coefficient width 12
  - coeff_t typedef
  - encoder state enum {ACCEPT, FLUSH}
- One sub-module is natural: enc_bit_accum, holding acc/fill with OR-insert and shift-out. Counters, state and handshakes stay in the top.

## Test plan
- D=12, coeffs 0x123, 0x456, byte_ready=1 → bytes 0x23, 0x61, 0x45.
- D=1, coeffs 1,0,1,1,0,0,0,1 → single byte 0x8D.
- D=4, coeff i = i%16, full frame:
  - 128 bytes; byte0=0x10, byte7=0xFE.
  - byte_last only on byte 127.
  - frame_done pulse one cycle later; coeff_ready high again.
- D=12, byte_ready low 5 cycles while byte_valid high → byte_o stable, coeff_ready=0, no bytes lost or duplicated.
- Macro on, D=10, coeff 0x400 → range_err=1 and stays 1; emitted bits equal packing of 0x000.
- Reset asserted after 100 coefficients at D=12 → all outputs at reset values next cycle. A subsequent full frame matches the golden 384 bytes.

Source files
------------

// File: rtl/kyber_pkg.sv
// kyber_pkg: constants and types shared by the polynomial datapath blocks.
// Holds the frame size, coefficient width, accumulator sizing and the
// encoder state enum.
package kyber_pkg;

    localparam int KYBER_N = 256;
    localparam int COEFF_W = 12;
    // Up to 7 pending bits plus one 12-bit coefficient: 19 bits of fill.
    localparam int ACC_W   = 20;
    localparam int FILL_W  = 5;

    typedef logic [COEFF_W-1:0] coeff_t;

    typedef enum logic {
        ACCEPT = 1'b0,
        FLUSH  = 1'b1
    } enc_state_e;

    // Mask selecting the low d bits of a coefficient.
    function automatic coeff_t coeff_mask(input int d);
        coeff_t m;
        for (int i = 0; i < COEFF_W; i++) begin
            m[i] = (i < d);
        end
        return m;
    endfunction

endpackage

// File: rtl/poly_byte_encode_if.sv
// poly_byte_encode_if: coefficient-in / byte-out handshake bundle for the
// byte encoder. The encoder uses the slave modport; the producer/consumer
// side uses master.
interface poly_byte_encode_if;
    import kyber_pkg::*;

    coeff_t      coeff_i;
    logic        coeff_valid;
    logic        coeff_ready;
    logic [7:0]  byte_o;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;
    logic        frame_done;

    modport master (
        output coeff_i, coeff_valid, byte_ready,
        input  coeff_ready, byte_o, byte_valid, byte_last, frame_done
    );

    modport slave (
        input  coeff_i, coeff_valid, byte_ready,
        output coeff_ready, byte_o, byte_valid, byte_last, frame_done
    );

endinterface

// File: rtl/enc_bit_accum.sv
// enc_bit_accum: bit accumulator for the byte encoder. Masked coefficients
// are OR-inserted above the pending bits; whole bytes shift out of the
// bottom. Load and shift are never requested together.
module enc_bit_accum
    import kyber_pkg::*;
#(
    parameter int D = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  coeff_t            i_bits,
    input  logic              i_shift,
    output logic [7:0]        o_byte,
    output logic [FILL_W-1:0] o_fill
);

    logic [ACC_W-1:0]  r_acc;
    logic [FILL_W-1:0] r_fill;

    // Insert a coefficient above the pending bits, or retire the low byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else if (i_load) begin
            r_acc  <= r_acc | (ACC_W'(i_bits) << r_fill);
            r_fill <= r_fill + FILL_W'(D);
        end else if (i_shift) begin
            r_acc  <= r_acc >> 8;
            r_fill <= r_fill - FILL_W'(8);
        end
    end

    assign o_byte = r_acc[7:0];
    assign o_fill = r_fill;

endmodule

// File: rtl/poly_byte_encode.sv
// poly_byte_encode: streams 256 coefficients in, packs their low D bits
// LSB-first and emits 32*D bytes per frame over a valid/ready interface.
// Optional macro ENCODE_RANGE_CHECK_EN adds the sticky range_err port,
// flagging accepted coefficients with bits set above D-1.
module poly_byte_encode
    import kyber_pkg::*;
#(
    parameter int D = 12
) (
    input  logic               clk,
    input  logic               reset,
    poly_byte_encode_if.slave  enc
`ifdef ENCODE_RANGE_CHECK_EN
    ,
    output logic               range_err
`endif
);

    localparam coeff_t            D_MASK     = coeff_mask(D);
    localparam int                N_BYTES    = 32 * D;
    localparam logic [8:0]        N_CNT      = 9'(KYBER_N);
    localparam logic [8:0]        LAST_COEFF = 9'(KYBER_N - 1);
    localparam logic [8:0]        LAST_BYTE  = 9'(N_BYTES - 1);
    localparam logic [FILL_W-1:0] FILL_BYTE  = FILL_W'(8);

    enc_state_e        r_state;
    logic [8:0]        r_coeff_cnt;
    logic [8:0]        r_byte_cnt;
    logic              r_frame_done;

    logic [7:0]        w_acc_lo;
    logic [FILL_W-1:0] w_fill;
    logic              w_coeff_ready;
    logic              w_byte_valid;
    logic              w_accept;
    logic              w_emit;
    logic              w_last_byte;
    coeff_t            w_bits;

    // Handshake qualifiers come from registered fill/counters only.
    assign w_coeff_ready = (w_fill < FILL_BYTE) && (r_coeff_cnt < N_CNT);
    assign w_byte_valid  = (w_fill >= FILL_BYTE);
    assign w_accept      = enc.coeff_valid && w_coeff_ready;
    assign w_emit        = w_byte_valid && enc.byte_ready;
    assign w_last_byte   = (r_byte_cnt == LAST_BYTE);
    assign w_bits        = enc.coeff_i & D_MASK;

    enc_bit_accum #(
        .D (D)
    ) u_accum (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_accept),
        .i_bits  (w_bits),
        .i_shift (w_emit),
        .o_byte  (w_acc_lo),
        .o_fill  (w_fill)
    );

    // Frame FSM: count coefficients in ACCEPT, drain and close the frame in FLUSH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ACCEPT;
            r_coeff_cnt  <= '0;
            r_byte_cnt   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_emit) begin
                r_byte_cnt <= w_last_byte ? 9'd0 : r_byte_cnt + 9'd1;
            end
            case (r_state)
                ACCEPT: begin
                    if (w_accept) begin
                        r_coeff_cnt <= r_coeff_cnt + 9'd1;
                        if (r_coeff_cnt == LAST_COEFF) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (w_emit && w_last_byte) begin
                        r_coeff_cnt  <= '0;
                        r_frame_done <= 1'b1;
                        r_state      <= ACCEPT;
                    end
                end
                default: r_state <= ACCEPT;
            endcase
        end
    end

    assign enc.coeff_ready = w_coeff_ready;
    assign enc.byte_valid  = w_byte_valid;
    assign enc.byte_o      = w_acc_lo;
    assign enc.byte_last   = w_byte_valid && w_last_byte;
    assign enc.frame_done  = r_frame_done;

`ifdef ENCODE_RANGE_CHECK_EN
    logic r_range_err;

    // Sticky flag for any accepted coefficient carrying bits above D-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_range_err <= 1'b0;
        end else if (w_accept && (|(enc.coeff_i & ~D_MASK))) begin
            r_range_err <= 1'b1;
        end
    end

    assign range_err = r_range_err;
`endif

endmodule
